// File: rtl/m6809_sys_glue.sv
// m6809_sys_glue: system-side bus glue for a 6809 CPU card.
// Synchronises E, decodes chip selects once per bus cycle, stretches UART
// cycles through MRDY, holds the remap/IRQ-mask control register and
// aggregates masked peripheral interrupts onto IRQ_B.
module m6809_sys_glue #(
  parameter logic [7:0] IO_PAGE     = 8'hFE,
  parameter logic [7:0] CTRL_ADDR   = 8'hFF,
  parameter logic [1:0] ROM_BASE    = 2'b11,
  parameter int         WAIT_CLKS   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        E_IN,
  input  logic [15:0] A,
  input  logic        RNW,
  input  logic        BS,
  input  logic        BA,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        A8SYS,
  output logic        CSUART_B,
  output logic        CSROM_B,
  output logic        CSRAM_B,
  output logic        MRDY,
  input  logic [3:0]  IRQ_SRC,
  output logic        IRQ_B
);

  typedef enum logic [1:0] {IDLE, STRETCH, HOLD} wait_state_t;

  logic [SYNC_STAGES-1:0] e_sync_p0;
  logic                   e_dly_p1;
  logic                   e_s;
  logic                   e_rise;
  logic                   e_fall;
  logic [3:0]             irq_sync_p0 [SYNC_STAGES];
  logic [7:0]             ctrl;
  logic [7:0]             d_in_masked;
  logic                   io_hit, ctrl_hit, uart_hit, rom_hit, ram_hit;
  logic                   sel_uart, sel_rom, sel_ram, ctrl_wr;
  logic                   irq_b_q;
  logic                   mrdy_q;
  logic [3:0]             wait_cnt;
  wait_state_t            state;

  assign e_s    = e_sync_p0[SYNC_STAGES-1];
  assign e_rise = e_s & ~e_dly_p1;
  assign e_fall = ~e_s & e_dly_p1;

  // Address decode; a granted/halted bus (BA=1) selects nothing.
  assign io_hit   = (A[15:8] == IO_PAGE) & ~BA;
  assign ctrl_hit = io_hit & (A[7:0] == CTRL_ADDR);
  assign uart_hit = io_hit & (A[7:0] != CTRL_ADDR);
  assign rom_hit  = ~io_hit & ~BA & (A[15:14] == ROM_BASE);
  assign ram_hit  = ~io_hit & ~BA & (A[15:14] != ROM_BASE);

  // Unused control bits [3:1] are forced to zero on write.
  assign d_in_masked = D_IN & 8'hF1;

  // Vector fetches (BS=1, BA=0) flip A8 while REMAP is set.
  assign A8SYS    = A[8] ^ (ctrl[0] & BS & ~BA);
  assign CSUART_B = ~sel_uart;
  assign CSROM_B  = ~sel_rom;
  assign CSRAM_B  = ~sel_ram;
  assign MRDY     = mrdy_q;
  assign IRQ_B    = irq_b_q;

  // Stage p0/p1: E synchroniser chain and delayed copy for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_sync_p0 <= '0;
      e_dly_p1  <= 1'b0;
    end else begin
      e_sync_p0 <= {e_sync_p0[SYNC_STAGES-2:0], E_IN};
      e_dly_p1  <= e_s;
    end
  end

  // Stage p0: IRQ source synchroniser chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) irq_sync_p0[i] <= 4'h0;
    end else begin
      irq_sync_p0[0] <= IRQ_SRC;
      for (int i = 1; i < SYNC_STAGES; i++) irq_sync_p0[i] <= irq_sync_p0[i-1];
    end
  end

  // Selects and control readback open on e_rise and close on e_fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_uart <= 1'b0;
      sel_rom  <= 1'b0;
      sel_ram  <= 1'b0;
      ctrl_wr  <= 1'b0;
      D_OE     <= 1'b0;
      D_OUT    <= 8'h00;
    end else if (e_rise) begin
      sel_uart <= uart_hit;
      sel_rom  <= rom_hit;
      sel_ram  <= ram_hit;
      ctrl_wr  <= ctrl_hit & ~RNW;
      D_OE     <= ctrl_hit & RNW;
      D_OUT    <= (ctrl_hit & RNW) ? ctrl : 8'h00;
    end else if (e_fall) begin
      sel_uart <= 1'b0;
      sel_rom  <= 1'b0;
      sel_ram  <= 1'b0;
      ctrl_wr  <= 1'b0;
      D_OE     <= 1'b0;
      D_OUT    <= 8'h00;
    end
  end

  // Control register captures write data at the end of the bus cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl <= 8'h01;
    end else if (e_fall && ctrl_wr) begin
      ctrl <= d_in_masked;
    end
  end

  // Wait FSM: hold MRDY low for WAIT_CLKS clocks on each UART access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      mrdy_q   <= 1'b1;
    end else if (e_rise && uart_hit) begin
      state    <= STRETCH;
      wait_cnt <= 4'(WAIT_CLKS);
      mrdy_q   <= 1'b0;
    end else begin
      case (state)
        STRETCH: begin
          if (wait_cnt == 4'd1) begin
            state    <= HOLD;
            wait_cnt <= 4'd0;
            mrdy_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (e_fall) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mrdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Stage p1: masked interrupt aggregation, one clock after the synchroniser.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_b_q <= 1'b1;
    end else begin
      irq_b_q <= ~|(irq_sync_p0[SYNC_STAGES-1] & ctrl[7:4]);
    end
  end

endmodule

// File: tb/tb_m6809_sys_glue.sv
// Directed bench for m6809_sys_glue: E is driven in step with CLK so the
// synchroniser latency is deterministic (E change -> select after 3 CLK).
`timescale 1ns/1ps
module tb_m6809_sys_glue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        E_IN;
  logic [15:0] A;
  logic        RNW, BS, BA;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE, A8SYS, CSUART_B, CSROM_B, CSRAM_B, MRDY;
  logic [3:0]  IRQ_SRC;
  logic        IRQ_B;

  int errors = 0;
  int checks = 0;

  m6809_sys_glue dut (
    .CLK(CLK), .RST(RST), .E_IN(E_IN), .A(A), .RNW(RNW), .BS(BS), .BA(BA),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .A8SYS(A8SYS),
    .CSUART_B(CSUART_B), .CSROM_B(CSROM_B), .CSRAM_B(CSRAM_B), .MRDY(MRDY),
    .IRQ_SRC(IRQ_SRC), .IRQ_B(IRQ_B)
  );

  // 16 MHz system clock
  always #31.25 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // E rises; after 3 CLK the decoded selects are visible (e_rise+1).
  task automatic rise_phase();
    E_IN = 1'b1;
    repeat (3) tick();
  endtask

  // E falls; after 3 CLK the selects have been released (e_fall+1).
  task automatic fall_phase();
    E_IN = 1'b0;
    repeat (3) tick();
  endtask

  task automatic bus(input logic [15:0] a, input logic rnw, input logic bs,
                     input logic ba, input logic [7:0] d);
    A = a; RNW = rnw; BS = bs; BA = ba; D_IN = d;
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    bus(16'hFEFF, 1'b0, 1'b0, 1'b0, d);
    rise_phase();
    repeat (5) tick();
    fall_phase();
    RNW = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    RST = 1'b1; E_IN = 1'b0; IRQ_SRC = 4'h0;
    bus(16'h0100, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check("rst_d_out", D_OUT, 16'h00);
    check("rst_d_oe", D_OE, 1'b0);
    check("rst_csuart", CSUART_B, 1'b1);
    check("rst_csrom", CSROM_B, 1'b1);
    check("rst_csram", CSRAM_B, 1'b1);
    check("rst_mrdy", MRDY, 1'b1);
    check("rst_irq_b", IRQ_B, 1'b1);
    check("rst_a8sys", A8SYS, 1'b1);
    RST = 1'b0;
    repeat (2) tick();

    // Vector fetch from ROM with remap set
    bus(16'hFFFE, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    check("s1_a8sys_remap", A8SYS, 1'b0);
    rise_phase();
    check("s1_csrom_low", CSROM_B, 1'b0);
    check("s1_csram_hi", CSRAM_B, 1'b1);
    check("s1_csuart_hi", CSUART_B, 1'b1);
    check("s1_mrdy0", MRDY, 1'b1);
    repeat (4) tick();
    check("s1_mrdy1", MRDY, 1'b1);
    fall_phase();
    check("s1_csrom_rel", CSROM_B, 1'b1);
    repeat (4) tick();

    // Plain RAM access
    bus(16'h1234, 1'b1, 1'b0, 1'b0, 8'h00);
    rise_phase();
    check("ram_csram_low", CSRAM_B, 1'b0);
    check("ram_csrom_hi", CSROM_B, 1'b1);
    repeat (5) tick();
    fall_phase();
    check("ram_csram_rel", CSRAM_B, 1'b1);
    repeat (4) tick();

    // Control register write F0, then read back
    bus(16'hFEFF, 1'b0, 1'b0, 1'b0, 8'hF0);
    rise_phase();
    check("s2w_no_rom", CSROM_B, 1'b1);
    check("s2w_no_ram", CSRAM_B, 1'b1);
    check("s2w_no_uart", CSUART_B, 1'b1);
    check("s2w_d_oe", D_OE, 1'b0);
    repeat (5) tick();
    fall_phase();
    RNW = 1'b1; D_IN = 8'h00;
    repeat (4) tick();
    rise_phase();
    check("s2r_d_oe", D_OE, 1'b1);
    check("s2r_d_out", D_OUT, 16'hF0);
    repeat (5) tick();
    fall_phase();
    check("s2r_d_oe_rel", D_OE, 1'b0);
    bus(16'hFFFE, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    check("s2_a8sys_noremap", A8SYS, 1'b1);
    check("s2_irq_idle", IRQ_B, 1'b1);
    repeat (4) tick();

    // UART access: MRDY low exactly 4 CLK
    bus(16'hFE10, 1'b1, 1'b0, 1'b0, 8'h00);
    rise_phase();
    check("s3_csuart_low", CSUART_B, 1'b0);
    check("s3_mrdy_c1", MRDY, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("s3_mrdy_c%0d", i), MRDY, 1'b0);
    end
    tick();
    check("s3_mrdy_rel", MRDY, 1'b1);
    tick();
    check("s3_csuart_held", CSUART_B, 1'b0);
    E_IN = 1'b0;
    repeat (2) tick();
    check("s3_csuart_efall", CSUART_B, 1'b0);
    tick();
    check("s3_csuart_rel", CSUART_B, 1'b1);
    check("s3_mrdy_end", MRDY, 1'b1);
    repeat (4) tick();

    // IRQ masking: mask = 0010
    ctrl_write(8'h20);
    IRQ_SRC = 4'b0001;
    repeat (5) tick();
    check("s4_irq_masked", IRQ_B, 1'b1);
    IRQ_SRC = 4'b0000;
    repeat (3) tick();
    IRQ_SRC = 4'b0010;
    repeat (2) tick();
    check("s4_irq_lat2", IRQ_B, 1'b1);
    tick();
    check("s4_irq_lat3", IRQ_B, 1'b0);
    IRQ_SRC = 4'b0000;
    repeat (3) tick();
    check("s4_irq_release", IRQ_B, 1'b1);

    // Reset during STRETCH
    bus(16'hFE10, 1'b1, 1'b0, 1'b0, 8'h00);
    rise_phase();
    tick();
    check("s5_mrdy_stretch", MRDY, 1'b0);
    RST = 1'b1;
    #1;
    check("s5_mrdy_async", MRDY, 1'b1);
    check("s5_csuart_async", CSUART_B, 1'b1);
    check("s5_d_oe_async", D_OE, 1'b0);
    E_IN = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    repeat (3) tick();
    bus(16'hFFFE, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    check("s5_remap_restored", A8SYS, 1'b0);
    bus(16'hFE10, 1'b1, 1'b0, 1'b0, 8'h00);
    rise_phase();
    check("s5_mrdy_c1", MRDY, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("s5_mrdy_c%0d", i), MRDY, 1'b0);
    end
    tick();
    check("s5_mrdy_rel", MRDY, 1'b1);
    tick();
    fall_phase();
    check("s5_csuart_rel", CSUART_B, 1'b1);
    repeat (4) tick();

    // Bus granted (BA=1): nothing selected, no remap
    bus(16'hFFFE, 1'b1, 1'b1, 1'b1, 8'h00);
    #1;
    check("s6_a8sys_ba", A8SYS, 1'b1);
    bus(16'hFE10, 1'b1, 1'b1, 1'b1, 8'h00);
    rise_phase();
    check("s6_csuart", CSUART_B, 1'b1);
    check("s6_csrom", CSROM_B, 1'b1);
    check("s6_csram", CSRAM_B, 1'b1);
    check("s6_mrdy", MRDY, 1'b1);
    check("s6_d_oe", D_OE, 1'b0);
    repeat (3) tick();
    check("s6_mrdy_later", MRDY, 1'b1);
    fall_phase();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
